mem_arbiter: RTL
================

# mem_arbiter

Shares one unified memory port between the core's instruction-fetch requester and data requester. Sits between `core` and the memory/bus model. It serialises accesses with one transaction outstanding, gives data priority with a bounded fetch-starvation guarantee, and routes each response back to the requester that owns it.

## Interface
- `ADDR_W`, default 64: address width.
- `DATA_W`, default 64: data width.
- `STARVE_LIMIT`, default 4, legal range ≥1: maximum consecutive data grants taken while fetch waits.

- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `if_req_i`  in  1  fetch request
- `if_addr_i`  in  ADDR_W  fetch address
- `if_gnt_o`  out  1  fetch request accepted (1-cycle pulse)
- `if_rvalid_o`  out  1  fetch response valid
- `if_rdata_o`  out  DATA_W  fetch read data
- `d_req_i`  in  1  data request
- `d_addr_i`  in  ADDR_W  data address
- `d_wr_i`  in  1  1 = write
- `d_byte_en_i`  in  2  access size code, passed through
- `d_wdata_i`  in  DATA_W  write data
- `d_gnt_o`  out  1  data request accepted (1-cycle pulse)
- `d_rvalid_o`  out  1  data response valid (read data or write ack)
- `d_rdata_o`  out  DATA_W  data read data
- `mem_req_o`, `mem_addr_o`, `mem_wr_o`, `mem_byte_en_o`, `mem_wdata_o`  out  1/ADDR_W/1/2/DATA_W  downstream request
- `mem_gnt_i`  in  1  downstream accepted request
- `mem_rvalid_i`  in  1  downstream response valid
- `mem_rdata_i`  in  DATA_W  downstream read data

## Operation
- FSM states: IDLE, REQ, RSP. Reset state: IDLE.
- **IDLE**
  - If any `*_req_i` is high, select a winner, latch its attributes and owner, pulse its `*_gnt_o`, and go to REQ.
  - Otherwise stay in IDLE.
- **Arbitration**
  - Only one requester high: that requester wins.
  - Both high: data wins, unless `streak_q == STARVE_LIMIT`, in which case fetch wins.
- **Streak counter `streak_q`**
  - Incremented on a data grant made while `if_req_i` = 1, saturating at STARVE_LIMIT.
  - Cleared on any fetch grant.
  - Unchanged otherwise.
- **REQ**
  - `mem_req_o` = 1, with `mem_*` driven from the latched registers only. They are stable until `mem_gnt_i`.
  - On `mem_gnt_i`, go to RSP.
- **RSP**
  - On `mem_rvalid_i`, route to the owner: `owner_rvalid_o` = 1 and `owner_rdata_o` = `mem_rdata_i`. Go to IDLE.
  - The non-owner's rvalid stays 0.
  - `*_rdata_o` is 0 whenever the matching `*_rvalid_o` is 0.
- `mem_rvalid_i` in IDLE or REQ is ignored and produces no output.
- Requesters hold `req` and attributes stable until gnt. After gnt they may drop or change them freely.
- Writes complete through `mem_rvalid_i` like reads; the requester receives rvalid with don't-care data.

## Timing
- Reset values: all `*_gnt_o`, `*_rvalid_o` and `mem_req_o` are 0. All data/address outputs are 0. `streak_q` is 0. State is IDLE.
- Asserting reset mid-transaction aborts immediately. No response is delivered, and the downstream memory must also be reset.
- `*_gnt_o` is combinational in the IDLE cycle.
- `mem_req_o` rises in the cycle after gnt.
- Downstream must not assert `mem_rvalid_i` earlier than the cycle after `mem_gnt_i`.
- Minimum transaction: T0 gnt, T1 `mem_req`+`mem_gnt`, T2 rvalid, T3 next grant possible. Throughput is one access per 3 cycles.
- `*_rvalid_o` and `*_rdata_o` are combinational from `mem_rvalid_i`/`mem_rdata_i`, gated by state = RSP and the owner.

## Structure
- Add to `cpu_consts`:
  - `arb_state_e` with values IDLE, REQ, RSP
  - `arb_owner_e` with values OWN_IF, OWN_D
  - default `STARVE_LIMIT` constant
- The arbiter is a single module. Winner selection may sit in a small combinational sub-module, `arb_prio_sel`, taking (`if_req`, `d_req`, `streak_at_limit`) and returning the owner.
- Streak counter width is `$clog2(STARVE_LIMIT+1)`.

## Test plan
- **Fetch alone:** `if_req` with addr 0x1000; memory grants at T1 and returns 0xDEADBEEF at T2 → `if_gnt` at T0, `mem_addr_o` = 0x1000 at T1, `if_rvalid` with 0xDEADBEEF at T2, `d_rvalid` = 0 throughout.
- **Simultaneous requests:** both request, data is a write to 0x2000 with wdata 0x55 → data granted first, `mem_wr_o` = 1 and `mem_wdata_o` = 0x55; fetch granted in the next IDLE.
- **Starvation bound:** `d_req` and `if_req` held high continuously with STARVE_LIMIT = 4 → exactly 4 data grants, then 1 fetch grant, repeating the pattern D,D,D,D,F.
- **Downstream stall:** `mem_gnt_i` withheld for 5 cycles → `mem_req_o` and `mem_addr_o` stay constant. Requester-side changes after gnt do not alter `mem_*`.
- **Reset mid-flight:** assert reset while in RSP → no rvalid is produced, all outputs go to 0, `streak_q` = 0, and a new `if_req` after release is granted in the first IDLE cycle.
- **Spurious rvalid:** `mem_rvalid_i` pulsed in IDLE → both `*_rvalid_o` stay 0 and the state is unchanged.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RSP
   } arb_state_e;

   typedef enum logic {
      OWN_IF,
      OWN_D
   } arb_owner_e;

   localparam int DEFAULT_STARVE_LIMIT = 4;

   // Instruction fetches always move a full-width word.
   localparam logic [1:0] FETCH_BYTE_EN = 2'b11;

endpackage

// File: rtl/mem_arbiter_prio_sel.sv
// Winner selection: data has priority unless fetch has been starved up to the limit.
module arb_prio_sel
   import mem_arbiter_pkg::*;
(
   input  logic       if_req,
   input  logic       d_req,
   input  logic       streak_at_limit,
   output arb_owner_e owner
);

   always_comb begin
      owner = OWN_D;
      if (if_req && (!d_req || streak_at_limit)) begin
         owner = OWN_IF;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and data accesses onto one memory port, one transaction outstanding,
// and routes each response back to the requester that owns it.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 64,
   parameter int DATA_W       = 64,
   parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [DATA_W-1:0] if_rdata_o,
   input  logic              d_req_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic              d_wr_i,
   input  logic [1:0]        d_byte_en_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic              d_gnt_o,
   output logic              d_rvalid_o,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_wr_o,
   output logic [1:0]        mem_byte_en_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   localparam int                  STREAK_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

   arb_state_e          state_q;
   arb_state_e          state_d;
   arb_owner_e          owner_q;
   arb_owner_e          winner;
   logic [ADDR_W-1:0]   addr_q;
   logic                wr_q;
   logic [1:0]          byte_en_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [STREAK_W-1:0] streak_q;
   logic                any_req;
   logic                streak_at_limit;

   assign any_req         = if_req_i | d_req_i;
   assign streak_at_limit = (streak_q == STREAK_MAX);

   arb_prio_sel u_prio_sel (
      .if_req          (if_req_i),
      .d_req           (d_req_i),
      .streak_at_limit (streak_at_limit),
      .owner           (winner)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (any_req)      state_d = REQ;
         REQ:     if (mem_gnt_i)    state_d = RSP;
         RSP:     if (mem_rvalid_i) state_d = IDLE;
         default:                   state_d = IDLE;
      endcase
   end

   // Grants and responses are combinational; reset forces every strobe low.
   always_comb begin
      if_gnt_o    = 1'b0;
      d_gnt_o     = 1'b0;
      mem_req_o   = 1'b0;
      if_rvalid_o = 1'b0;
      d_rvalid_o  = 1'b0;
      if_rdata_o  = '0;
      d_rdata_o   = '0;
      if (!reset) begin
         unique case (state_q)
            IDLE: begin
               if_gnt_o = any_req && (winner == OWN_IF);
               d_gnt_o  = any_req && (winner == OWN_D);
            end
            REQ: mem_req_o = 1'b1;
            RSP: begin
               if (mem_rvalid_i) begin
                  if (owner_q == OWN_IF) begin
                     if_rvalid_o = 1'b1;
                     if_rdata_o  = mem_rdata_i;
                  end else begin
                     d_rvalid_o = 1'b1;
                     d_rdata_o  = mem_rdata_i;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Attributes are captured at grant so requesters may change them freely afterwards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_q   <= OWN_IF;
         addr_q    <= '0;
         wr_q      <= 1'b0;
         byte_en_q <= '0;
         wdata_q   <= '0;
         streak_q  <= '0;
      end else if ((state_q == IDLE) && any_req) begin
         owner_q <= winner;
         if (winner == OWN_IF) begin
            addr_q    <= if_addr_i;
            wr_q      <= 1'b0;
            byte_en_q <= FETCH_BYTE_EN;
            wdata_q   <= '0;
            streak_q  <= '0;
         end else begin
            addr_q    <= d_addr_i;
            wr_q      <= d_wr_i;
            byte_en_q <= d_byte_en_i;
            wdata_q   <= d_wdata_i;
            if (if_req_i && !streak_at_limit) begin
               streak_q <= streak_q + 1'b1;
            end
         end
      end
   end

   assign mem_addr_o    = addr_q;
   assign mem_wr_o      = wr_q;
   assign mem_byte_en_o = byte_en_q;
   assign mem_wdata_o   = wdata_q;

endmodule
